// File: rtl/mem_word_arbiter_if.sv
// Bus bundle between the two requesting ports (fetch, data), the word
// arbiter, and the byte-wide memory slave. The arbiter side uses the
// slave modport; the core/memory environment uses the master modport.
interface mem_word_arbiter_if #(
  parameter int MEM_AW = 10
);
  // Instruction-fetch port (read only)
  logic              i_req;
  logic [MEM_AW-2:0] i_addr;
  logic [15:0]       i_rdata;
  logic              i_done;

  // Data port (read/write)
  logic              d_req;
  logic              d_we;
  logic [MEM_AW-2:0] d_addr;
  logic [15:0]       d_wdata;
  logic [15:0]       d_rdata;
  logic              d_done;

  logic              busy;

  // Byte-wide memory slave
  logic [MEM_AW-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [7:0]        mem_writedata;
  logic [7:0]        mem_readdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_readdata,
    output i_rdata, i_done, d_rdata, d_done, busy,
           mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_readdata,
    input  i_rdata, i_done, d_rdata, d_done, busy,
           mem_address, mem_chipselect, mem_clken, mem_write, mem_writedata
  );
endinterface

// File: rtl/mem_word_arbiter.sv
// Two-port word arbiter / sequencer in front of an 8-bit memory.
// Each 16-bit word request becomes two big-endian byte accesses
// (high byte at {W,0}, low byte at {W,1}). Ties between the fetch and
// data ports are broken round-robin; data wins the first tie after reset.
module mem_word_arbiter #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  mem_word_arbiter_if.slave bus
);

  localparam int WAW = MEM_AW - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    RD_CAP,
    WR_HI,
    WR_LO,
    DONE
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  state_e          state_q;
  port_e           grant_q;
  port_e           rr_last_q;
  logic [WAW-1:0]  addr_q;
  logic [7:0]      wdata_lo_q;
  logic [7:0]      hi_q;
  logic [15:0]     i_rdata_q;
  logic [15:0]     d_rdata_q;
  logic            i_done_q;
  logic            d_done_q;
  logic            busy_q;
  logic [MEM_AW-1:0] mem_address_q;
  logic [7:0]      mem_writedata_q;
  logic            mem_cs_q;
  logic            mem_write_q;

  logic            grant_valid_d;
  port_e           grant_d;
  logic [WAW-1:0]  addr_d;
  logic            we_d;

  // Pick the port to serve from the live requests; only consumed in IDLE.
  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_valid_d = bus.i_req | bus.d_req;
    grant_d       = PORT_D;
    if (bus.i_req && bus.d_req) begin
      grant_d = (rr_last_q == PORT_D) ? PORT_I : PORT_D;
    end else if (bus.i_req) begin
      grant_d = PORT_I;
    end
    addr_d = (grant_d == PORT_D) ? bus.d_addr : bus.i_addr;
    we_d   = (grant_d == PORT_D) & bus.d_we;
  end

  // Sequencer FSM; every output is produced by a register updated here.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= PORT_I;
      rr_last_q       <= PORT_I;
      addr_q          <= '0;
      wdata_lo_q      <= '0;
      hi_q            <= '0;
      i_rdata_q       <= '0;
      d_rdata_q       <= '0;
      i_done_q        <= 1'b0;
      d_done_q        <= 1'b0;
      busy_q          <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_cs_q        <= 1'b0;
      mem_write_q     <= 1'b0;
    end else begin
      // Memory strobes and done pulses default to idle each cycle.
      i_done_q        <= 1'b0;
      d_done_q        <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      mem_cs_q        <= 1'b0;
      mem_write_q     <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            grant_q       <= grant_d;
            addr_q        <= addr_d;
            wdata_lo_q    <= bus.d_wdata[7:0];
            busy_q        <= 1'b1;
            // Outputs for the first byte access are set up on the way out.
            mem_address_q <= {addr_d, 1'b0};
            mem_cs_q      <= 1'b1;
            if (we_d) begin
              state_q         <= WR_HI;
              mem_write_q     <= 1'b1;
              mem_writedata_q <= bus.d_wdata[15:8];
            end else begin
              state_q <= RD_HI;
            end
          end
        end

        RD_HI: begin
          state_q       <= RD_LO;
          mem_address_q <= {addr_q, 1'b1};
          mem_cs_q      <= 1'b1;
        end

        RD_LO: begin
          // High byte arrives one cycle after its address was presented.
          state_q <= RD_CAP;
          hi_q    <= bus.mem_readdata;
        end

        RD_CAP: begin
          state_q <= DONE;
          if (grant_q == PORT_D) begin
            d_rdata_q <= {hi_q, bus.mem_readdata};
            d_done_q  <= 1'b1;
          end else begin
            i_rdata_q <= {hi_q, bus.mem_readdata};
            i_done_q  <= 1'b1;
          end
        end

        WR_HI: begin
          state_q         <= WR_LO;
          mem_address_q   <= {addr_q, 1'b1};
          mem_writedata_q <= wdata_lo_q;
          mem_cs_q        <= 1'b1;
          mem_write_q     <= 1'b1;
        end

        WR_LO: begin
          // Only the data port can write.
          state_q  <= DONE;
          d_done_q <= 1'b1;
        end

        DONE: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          rr_last_q <= grant_q;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_rdata       = i_rdata_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.i_done        = i_done_q;
  assign bus.d_done        = d_done_q;
  assign bus.busy          = busy_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;
  // Strobes are suppressed while reset is high so a reset landing in
  // WR_LO aborts the low-byte write instead of letting it complete.
  assign bus.mem_chipselect = mem_cs_q & ~reset;
  assign bus.mem_clken      = mem_cs_q & ~reset;
  assign bus.mem_write      = mem_write_q & ~reset;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Testbench for mem_word_arbiter: byte-wide memory slave, a word-level
// reference model (byte array + round-robin rule + fixed latencies),
// a vector table, hand-written corner sequences and random traffic.
module tb_mem_word_arbiter;

  localparam int MEM_AW = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_word_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

  mem_word_arbiter #(.MEM_AW(MEM_AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory slave contents and the reference model's view of them.
  logic [7:0]  mem     [1024];
  logic        mem_ready = 1'b0;
  logic [7:0]  ref_mem [1024];
  logic [15:0] exp_i_rdata;
  logic [15:0] exp_d_rdata;
  bit          last_d;   // port served last: 1 = data, 0 = fetch

  typedef struct {
    bit          is_d;
    bit          we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_i;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] init_byte(input int a);
    if (a == 'h3FE) return 8'h12;
    if (a == 'h3FF) return 8'h34;
    return a[7:0];
  endfunction

  // Byte memory with one-cycle read latency.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) mem[k] <= init_byte(k);
      mem_ready <= 1'b1;
    end else if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
      else               bus.mem_readdata     <= mem[bus.mem_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_i_done"}, 32'(bus.i_done), 0);
    check({tag, "_d_done"}, 32'(bus.d_done), 0);
    check({tag, "_i_rdata"}, 32'(bus.i_rdata), 0);
    check({tag, "_d_rdata"}, 32'(bus.d_rdata), 0);
    check({tag, "_mem_addr"}, 32'(bus.mem_address), 0);
    check({tag, "_mem_cs"}, 32'(bus.mem_chipselect), 0);
    check({tag, "_mem_clken"}, 32'(bus.mem_clken), 0);
    check({tag, "_mem_write"}, 32'(bus.mem_write), 0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_writedata), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero(tag);
    reset = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    last_d = 1'b0;
  endtask

  // Issue requests on the chosen ports and follow them to completion using
  // the reference rules: winner by round-robin, read done 4 cycles after the
  // grant, write done 3 cycles after, one IDLE cycle between transactions.
  // Entered and left on a falling edge with the arbiter idle.
  task automatic run_pair(input bit use_i, input bit use_d, input logic [8:0] ia,
                          input logic [8:0] da, input bit dwe, input logic [15:0] dwd);
    bit          pend_i, pend_d, cur_d, cwe, fin;
    logic [8:0]  ca;
    logic [15:0] w;
    int          g, lat;
    if (!use_i && !use_d) return;
    pend_i = use_i;
    pend_d = use_d;
    cur_d  = (use_i && use_d) ? !last_d : use_d;
    bus.i_req   = use_i;
    bus.i_addr  = ia;
    bus.d_req   = use_d;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    check("busy_at_grant", 32'(bus.busy), 0);
    g   = 0;
    fin = 1'b0;
    ca  = cur_d ? da : ia;
    cwe = cur_d && dwe;
    lat = cwe ? 3 : 4;
    for (int c = 1; !fin; c++) begin
      @(negedge clk);
      check("i_done", 32'(bus.i_done), 32'(!cur_d && c == g + lat));
      check("d_done", 32'(bus.d_done), 32'(cur_d && c == g + lat));
      if (c == g && g != 0) check("busy_idle", 32'(bus.busy), 0);
      if (c == g + 1 || c == g + 2) begin
        check("mem_address", 32'(bus.mem_address), 32'({ca, 1'(c == g + 2)}));
        check("mem_cs", 32'(bus.mem_chipselect), 1);
        check("mem_write", 32'(bus.mem_write), 32'(cwe));
        check("mem_wdata", 32'(bus.mem_writedata),
              cwe ? 32'((c == g + 1) ? dwd[15:8] : dwd[7:0]) : 32'h0);
        check("busy_active", 32'(bus.busy), 1);
      end else if (c == g + 3 && !cwe) begin
        check("mem_cs_cap", 32'(bus.mem_chipselect), 0);
      end
      if (c == g + lat) begin
        if (cwe) begin
          ref_mem[{ca, 1'b0}] = dwd[15:8];
          ref_mem[{ca, 1'b1}] = dwd[7:0];
        end else begin
          w = {ref_mem[{ca, 1'b0}], ref_mem[{ca, 1'b1}]};
          if (cur_d) exp_d_rdata = w;
          else       exp_i_rdata = w;
        end
        check("i_rdata", 32'(bus.i_rdata), 32'(exp_i_rdata));
        check("d_rdata", 32'(bus.d_rdata), 32'(exp_d_rdata));
        last_d = cur_d;
        if (cur_d) begin
          pend_d    = 1'b0;
          bus.d_req = 1'b0;
        end else begin
          pend_i    = 1'b0;
          bus.i_req = 1'b0;
        end
        if (pend_i || pend_d) begin
          cur_d = pend_d;
          g     = c + 1;
          ca    = cur_d ? da : ia;
          cwe   = cur_d && dwe;
          lat   = cwe ? 3 : 4;
        end else begin
          fin = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("busy_after", 32'(bus.busy), 0);
    check("i_done_after", 32'(bus.i_done), 0);
    check("d_done_after", 32'(bus.d_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.i_req       = 1'b0;
    bus.i_addr      = '0;
    bus.d_req       = 1'b0;
    bus.d_we        = 1'b0;
    bus.d_addr      = '0;
    bus.d_wdata     = '0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_byte(k);

    vecs[0] = '{1'b1, 1'b1, 9'h005, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 9'h005, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 9'h1FF, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b1, 1'b1, 9'h100, 16'h0A5A, 16'h1234, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 9'h100, 16'h0000, 16'h1234, 16'h0A5A};
    vecs[5] = '{1'b0, 1'b0, 9'h000, 16'h0000, 16'h0001, 16'h0A5A};
    vecs[6] = '{1'b1, 1'b0, 9'h010, 16'h0000, 16'h0001, 16'h2021};

    do_reset("reset0");

    // Vector table: single-port transactions with constant expectations.
    for (int v = 0; v < 7; v++) begin
      run_pair(!vecs[v].is_d, vecs[v].is_d, vecs[v].addr, vecs[v].addr,
               vecs[v].we, vecs[v].wdata);
      check($sformatf("vec%0d_i_rdata", v), 32'(bus.i_rdata), 32'(vecs[v].exp_i));
      check($sformatf("vec%0d_d_rdata", v), 32'(bus.d_rdata), 32'(vecs[v].exp_d));
    end

    // Tie from reset with both requests held: D, I, D, I, 5 cycles apart.
    do_reset("reset1");
    bus.i_addr = 9'h1FF;
    bus.d_addr = 9'h010;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("tie_d_done", 32'(bus.d_done), 32'(c == 4 || c == 14));
      check("tie_i_done", 32'(bus.i_done), 32'(c == 9 || c == 19));
      check("tie_busy", 32'(bus.busy), 32'((c % 5) != 0));
      if (c == 4 || c == 14) check("tie_d_rdata", 32'(bus.d_rdata), 32'h2021);
      if (c == 9 || c == 19) check("tie_i_rdata", 32'(bus.i_rdata), 32'h1234);
      if (c == 19) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    last_d      = 1'b0;
    exp_i_rdata = 16'h1234;
    exp_d_rdata = 16'h2021;

    // Chained data reads: req held across d_done, new address 0x011.
    bus.d_addr = 9'h010;
    bus.d_we   = 1'b0;
    bus.d_req  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("chain_d_done", 32'(bus.d_done), 32'(c == 4 || c == 9));
      check("chain_i_done", 32'(bus.i_done), 0);
      if (c == 6) check("chain_mem_addr", 32'(bus.mem_address), 32'h022);
      if (c == 4) begin
        check("chain_rdata0", 32'(bus.d_rdata), 32'h2021);
        bus.d_addr = 9'h011;
      end
      if (c == 9) begin
        check("chain_rdata1", 32'(bus.d_rdata), 32'h2223);
        bus.d_req = 1'b0;
      end
      if (c == 10) check("chain_busy_end", 32'(bus.busy), 0);
    end
    check("chain_i_kept", 32'(bus.i_rdata), 32'h1234);
    last_d      = 1'b1;
    exp_d_rdata = 16'h2223;

    // Reset while in WR_LO: only the high byte lands in memory.
    bus.d_addr  = 9'h020;
    bus.d_we    = 1'b1;
    bus.d_wdata = 16'hC3A5;
    bus.d_req   = 1'b1;
    @(negedge clk);
    check("rstwr_hi_addr", 32'(bus.mem_address), 32'h040);
    check("rstwr_hi_write", 32'(bus.mem_write), 1);
    @(negedge clk);
    check("rstwr_lo_addr", 32'(bus.mem_address), 32'h041);
    check("rstwr_lo_wdata", 32'(bus.mem_writedata), 32'hA5);
    reset     = 1'b1;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clk);
    check_all_zero("rstwr");
    reset       = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    last_d      = 1'b0;
    ref_mem[10'h040] = 8'hC3;
    repeat (2) begin
      @(negedge clk);
      check("rstwr_no_done", 32'(bus.d_done), 0);
      check("rstwr_idle", 32'(bus.busy), 0);
    end
    run_pair(1'b0, 1'b1, 9'h000, 9'h020, 1'b0, 16'h0000);
    check("rstwr_readback", 32'(bus.d_rdata), 32'hC341);

    // Random traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 40; n++) begin
      int m;
      m = $urandom_range(1, 3);
      run_pair(m[0], m[1], 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_word_arbiter.md
# mem_word_arbiter

Two-port arbiter and sequencer between the 16-bit IITB-RISC core and the 8-bit on-chip memory of the memory system. Serves an instruction-fetch port (read only) and a data port (read/write). Converts each 16-bit word request into two byte accesses on the memory slave. Round-robin arbitration when both ports request.

## Interface

- MEM_AW, 10, memory byte-address width; word address width is MEM_AW-1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request, held until i_done
- i_addr  in  MEM_AW-1  fetch word address
- i_rdata  out  16  fetch read data, valid while i_done=1
- i_done  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  1=write, 0=read
- d_addr  in  MEM_AW-1  data word address
- d_wdata  in  16  write data
- d_rdata  out  16  data read data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- mem_address  out  MEM_AW  byte address to memory slave
- mem_chipselect  out  1  memory select
- mem_clken  out  1  memory clock enable
- mem_write  out  1  memory write strobe
- mem_writedata  out  8  byte write data
- mem_readdata  in  8  byte read data, 1-cycle read latency

## Operation

- Byte order: big-endian. Word W: high byte at byte address {W,0}, low byte at {W,1}.
- Requester rule: i_addr/d_addr/d_we/d_wdata stable from req rise until done cycle inclusive. Requester may hold req high after done to chain a new request; it is sampled again only in IDLE.
- States: IDLE, RD_HI, RD_LO, RD_CAP, WR_HI, WR_LO, DONE.
- IDLE: if exactly one req high, grant it. If both high, grant port not served last (rr_last flag); after reset data port wins first tie. Latch grant, address, we, wdata. Go RD_HI (fetch, or data with d_we=0) or WR_HI (data with d_we=1). No req: stay IDLE.
- RD_HI: mem_address={addr,0}, cs=1, clken=1, write=0 -> RD_LO.
- RD_LO: mem_address={addr,1}, cs=1, clken=1, write=0; capture mem_readdata into hi byte at end of cycle -> RD_CAP.
- RD_CAP: cs=0; capture mem_readdata into lo byte -> DONE.
- WR_HI: mem_address={addr,0}, writedata=wdata[15:8], cs=1, clken=1, write=1 -> WR_LO.
- WR_LO: mem_address={addr,1}, writedata=wdata[7:0], cs=1, clken=1, write=1 -> DONE.
- DONE: granted port's done=1 for exactly this cycle; rdata presents assembled word (reads); for writes rdata holds its previous value. Update rr_last to granted port -> IDLE.
- Non-granted port's req is ignored until next IDLE; its done stays 0.
- i_rdata and d_rdata are registered; each changes only on completion of a read for that port.
- Memory outputs outside access states: mem_address=0, mem_writedata=0, mem_chipselect=0, mem_clken=0, mem_write=0.

## Timing

- Reset values: state IDLE, busy=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, all mem_* outputs 0, rr_last=fetch (so data wins the first tie).
- Request sampled in IDLE cycle T. Read: memory accesses at T+1, T+2; done at T+4. Write: memory writes at T+1, T+2; done at T+3.
- Minimum request-to-request period: read 5 cycles, write 4 cycles (DONE -> IDLE -> next grant).
- Simultaneous i_req, d_req continuously high: grants alternate D, I, D, I ...
- Reset during any state: next cycle IDLE, in-flight request dropped with no done pulse; a half-completed write may leave only the high byte written.
- All outputs are driven by registers or state decode only; no combinational path from req inputs to memory outputs.

## Test plan

- Reset mid-write: assert reset in WR_LO -> next cycle IDLE, all outputs 0, no d_done; then d_req read of the same word returns the written high byte with the old low byte.
- Data write then read: d_we=1, d_addr=0x05, d_wdata=0xBEEF -> byte 0x00A written 0xBE at T+1, byte 0x00B written 0xEF at T+2, d_done at T+3; then d_we=0, d_addr=0x05 -> d_rdata=0xBEEF with d_done 4 cycles after grant.
- Fetch of top word: i_addr=0x1FF, memory bytes 0x3FE=0x12, 0x3FF=0x34 -> mem_address 0x3FE then 0x3FF, i_rdata=0x1234, i_done one cycle, d_done stays 0.
- Tie arbitration: i_req and d_req held high from reset with reads -> service order data, fetch, data, fetch; each done pulse exactly one cycle, busy low exactly one cycle (IDLE) between transactions.
- Chained requests: d_req held high across d_done with new d_addr 0x10 then 0x11 (reads) -> two back-to-back transactions, 5 cycles apart, correct data each.
- Port isolation: data read of 0x0A5A completes while i_req low -> i_rdata unchanged from prior value 0x1234.
